// File: rtl/regfile_dumper_if.sv
// Bus bundle between the register-file dumper and its environment.
// The master side is the dumper: it drives the read address and the
// dump stream; the slave side is the register file plus the consumer.
interface regfile_dumper_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             dout_valid;
  logic             dout_ready;
  logic [WIDTH-1:0] dout_data;
  logic [4:0]       dout_idx;
  logic             busy;
  logic             done;

  modport master (
    input  start,
    output rd_addr,
    input  rd_data,
    output dout_valid,
    input  dout_ready,
    output dout_data,
    output dout_idx,
    output busy,
    output done
  );

  modport slave (
    output start,
    input  rd_addr,
    output rd_data,
    input  dout_valid,
    output dout_ready,
    input  dout_data,
    input  dout_idx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/regfile_dumper.sv
// regfile_dumper: walks a 32-entry register file and streams every entry
// out as (index, value) over a valid/ready handshake, then pulses done.
// Optional build macro REGFILE_DUMP_SKIP_ZERO_EN: start the walk at x1 so
// the hard-wired x0 is never emitted (31 entries instead of 32).
module regfile_dumper #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  regfile_dumper_if.master bus
);

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
  localparam logic [4:0] FIRST_IDX = 5'd1;
`else
  localparam logic [4:0] FIRST_IDX = 5'd0;
`endif
  localparam logic [4:0] LAST_IDX = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [4:0]       r_idx;
  logic [4:0]       w_idx_next;
  logic [WIDTH-1:0] r_dout_data;
  logic [4:0]       r_dout_idx;

  logic [4:0]       w_rd_addr;
  logic             w_dout_valid;
  logic             w_busy;
  logic             w_done;

  // State and walk index; reset forces IDLE immediately so every
  // state-decoded output drops without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 5'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Capture the read data on the ADDR edge; held untouched through SEND so
  // the entry stays stable under backpressure. A register-file write on the
  // same edge is not seen here, so the pre-write value is what gets dumped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_data <= '0;
      r_dout_idx  <= 5'd0;
    end else if (r_state == ADDR) begin
      r_dout_data <= bus.rd_data;
      r_dout_idx  <= r_idx;
    end
  end

  // Next-state and output decode; start only matters in IDLE, and DONE
  // always returns to IDLE so a held start cannot chain dumps back-to-back.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_rd_addr    = r_idx;
    w_dout_valid = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_rd_addr = 5'd0;
        w_busy    = 1'b0;
        if (bus.start) begin
          w_idx_next   = FIRST_IDX;
          w_state_next = ADDR;
        end
      end
      ADDR: begin
        w_state_next = SEND;
      end
      SEND: begin
        w_dout_valid = 1'b1;
        if (bus.dout_ready) begin
          if (r_idx == LAST_IDX) begin
            w_state_next = DONE;
          end else begin
            w_idx_next   = r_idx + 5'd1;
            w_state_next = ADDR;
          end
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.rd_addr    = w_rd_addr;
  assign bus.dout_valid = w_dout_valid;
  assign bus.dout_data  = r_dout_data;
  assign bus.dout_idx   = r_dout_idx;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: the stimulus thread queues the
// expected (index, value) stream for each dump, a monitor pops and compares
// every accepted entry. Works with or without REGFILE_DUMP_SKIP_ZERO_EN.
module tb_regfile_dumper;
  localparam int WIDTH = 32;
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int N_ENT = 32 - FIRST;
  localparam logic [31:0] MID_VAL  = 32'hCAFE_0005;
  localparam logic [31:0] LATE_VAL = 32'hDEAD_0005;

  typedef struct packed {
    logic [4:0]       idx;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  logic [WIDTH-1:0] regs [32];
  entry_t exp_q [$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  regfile_dumper_if #(.WIDTH(WIDTH)) bus ();

  regfile_dumper #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rd_data = regs[bus.rd_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fill_regs();
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h1111;
  endtask

  // Queue the full expected stream for one dump.
  task automatic push_dump(input bit mid_write);
    entry_t e;
    for (int i = FIRST; i < 32; i++) begin
      e.idx  = 5'(i);
      e.data = (mid_write && i == 5) ? MID_VAL : 32'(i) * 32'h1111;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts edges until done is visible just after an edge.
  task automatic wait_done(output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1 cyc++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 400 cycles required done");
    end
  endtask

  // mode 0: ADDR cycle of index val; mode 1: SEND cycle of index val.
  task automatic wait_at(input int mode, input int val);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (mode == 0 && bus.busy && !bus.dout_valid && !bus.done && bus.rd_addr == 5'(val)) begin
        ok = 1'b1;
        break;
      end
      if (mode == 1 && bus.dout_valid && bus.dout_idx == 5'(val)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: got no state mode %0d idx %0d required reached", mode, val);
    end
  endtask

  // Monitor: one line per accepted entry, compared against the queue head.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.done) done_cnt++;
      if (!rst && bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry: got idx %0d data %0h required none", bus.dout_idx, bus.dout_data);
        end else begin
          e = exp_q.pop_front();
          chk("entry_idx", 64'(bus.dout_idx), 64'(e.idx));
          chk("entry_data", 64'(bus.dout_data), 64'(e.data));
          $display("entry idx=%0d data=%0h", bus.dout_idx, bus.dout_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int d0;
    logic [WIDTH-1:0] held_data;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.dout_ready = 1'b1;
    fill_regs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.dout_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
    chk("rst_dout_data", 64'(bus.dout_data), 64'd0);
    chk("rst_dout_idx", 64'(bus.dout_idx), 64'd0);
    @(negedge clk) rst = 1'b0;

    // Dump 1: full-rate stream, latency to done.
    push_dump(1'b0);
    d0 = done_cnt;
    pulse_start();
    wait_done(cyc);
    chk("done_cycle", 64'(cyc + 1), 64'(2 * N_ENT + 1));
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("idle_after_done", 64'(bus.busy), 64'd0);
    chk("dump1_all_seen", 64'(exp_q.size()), 64'd0);
    chk("dump1_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Dump 2: write during the ADDR cycle of x5, then backpressure at x7.
    fill_regs();
    push_dump(1'b1);
    pulse_start();
    wait_at(0, 5);
    regs[5] = MID_VAL;
    @(posedge clk);
    regs[5] <= LATE_VAL;
    #1;
    chk("capture_addr_value", 64'(bus.dout_data), 64'(MID_VAL));
    wait_at(1, 7);
    bus.dout_ready = 1'b0;
    held_data = bus.dout_data;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(bus.dout_valid), 64'd1);
      chk("bp_data", 64'(bus.dout_data), 64'(held_data));
      chk("bp_idx", 64'(bus.dout_idx), 64'd7);
    end
    bus.dout_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_valid", 64'(bus.dout_valid), 64'd0);
    chk("resume_rd_addr", 64'(bus.rd_addr), 64'd8);
    wait_done(cyc);
    @(posedge clk);
    chk("dump2_all_seen", 64'(exp_q.size()), 64'd0);

    // Dump 3: reset in SEND at x12 aborts with no done.
    fill_regs();
    push_dump(1'b0);
    pulse_start();
    wait_at(1, 12);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 64'(bus.dout_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_rd_addr", 64'(bus.rd_addr), 64'd0);
    chk("abort_dout_data", 64'(bus.dout_data), 64'd0);
    chk("abort_dout_idx", 64'(bus.dout_idx), 64'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_stays_idle", 64'(bus.busy), 64'd0);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // Dump 4: start held through the dump and DONE; restarts at first index.
    push_dump(1'b0);
    d0 = done_cnt;
    @(negedge clk) bus.start = 1'b1;
    wait_done(cyc);
    @(posedge clk);
    #1;
    chk("held_start_gap", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("held_start_idle", 64'(bus.busy), 64'd0);
    chk("held_start_pulses", 64'(done_cnt - d0), 64'd1);
    chk("dump4_all_seen", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 SHALL have parameter WIDTH, default 32, setting the register data width.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-005 SHALL have port rd_addr  output  5  read address driven to the register-file read port.
REQ-006 SHALL have port rd_data  input  WIDTH  combinational read data returned for rd_addr.
REQ-007 SHALL have port dout_valid  output  1  dout_data/dout_idx hold a valid entry.
REQ-008 SHALL have port dout_ready  input  1  consumer accepts the entry when high together with dout_valid.
REQ-009 SHALL have port dout_data  output  WIDTH  captured register value.
REQ-010 SHALL have port dout_idx  output  5  register index of dout_data.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last entry is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR, SEND, DONE; a 5-bit index register idx; and output registers dout_data and dout_idx.
REQ-014 IDLE: rd_addr=0, busy=0; start=1 -> idx:=first index, go to ADDR; start=0 -> stay.
REQ-015 ADDR: rd_addr=idx; at the edge, dout_data:=rd_data and dout_idx:=idx; go to SEND. No wait state (rd_data is same-cycle).
REQ-016 SEND: dout_valid=1 and rd_addr=idx; dout_data/dout_idx SHALL stay stable until the handshake completes.
REQ-017 SEND with dout_ready=1: if idx==31, go to DONE; otherwise idx:=idx+1 and go to ADDR. With dout_ready=0, stay in SEND.
REQ-018 DONE: done=1 for exactly one cycle, then go to IDLE. idx SHALL never wrap past 31.
REQ-019 start SHALL be ignored in ADDR, SEND and DONE. start in the same cycle as DONE SHALL NOT begin a new dump.
REQ-020 dout_valid SHALL be 1 only in SEND. done SHALL be 1 only in DONE.
REQ-021 Each value is captured at its ADDR edge. A register-file write to the same register on that same edge SHALL return the pre-write value; the dump is not an atomic snapshot.
REQ-022 Throughput with dout_ready held at 1: one entry per 2 cycles.

Reset
REQ-023 Asserting rst SHALL immediately force: state=IDLE, idx=0, dout_data=0, dout_idx=0, dout_valid=0, busy=0, done=0, rd_addr=0.
REQ-024 rst asserted mid-dump SHALL abort the dump with no done pulse. After rst deasserts, the block SHALL wait in IDLE for a new start.

Configuration
REQ-025 Macro REGFILE_DUMP_SKIP_ZERO_EN: when defined, the first index SHALL be 1, so x0 is never emitted (31 entries). When undefined, the first index SHALL be 0 (32 entries).

Verification
REQ-026 Without macro: rd_data models regs[i]=i*16'h1111; pulse start; hold dout_ready=1 -> 32 entries, dout_idx 0..31, data matching the model, done exactly 65 cycles after the start-sampling edge.
REQ-027 With REGFILE_DUMP_SKIP_ZERO_EN: same stimulus -> 31 entries, dout_idx 1..31, done 63 cycles after the start-sampling edge.
REQ-028 Backpressure: drop dout_ready for 5 cycles while in SEND at idx=7 -> dout_valid stays high and dout_data/dout_idx are unchanged; the next entry begins only after ready returns.
REQ-029 Reset mid-dump: assert rst while in SEND at idx=12 -> all outputs are 0 immediately (before the next edge); no done pulse; a later start restarts at the first index.
REQ-030 start held high for the whole dump and during DONE -> exactly one dump and one done pulse; busy falls to 0 for at least one cycle before any restart.
REQ-031 Concurrent write: change rd_data on the ADDR cycle of idx=5 -> the captured dout_data equals the value present during the ADDR cycle.
